rf_freq_counter: RTL
====================

Name: rf_freq_counter

Overview:
- Digital measurement stage directly downstream of the RF test macro.
- Consumes the macro's asynchronous test output (oscillator or divided RF tap), synchronises it into the system clock domain and counts its rising edges over a programmable gate window.
- Presents the count through a valid/ready result port to the readout logic.

Parameters:
- CNT_W, 16, width of edge counter and result.
- GATE_W, 24, width of gate-length input and internal gate down-counter.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Asynchronous assertion, active-low, clears all state.
- sig_in  in  1  asynchronous test signal from the RF macro.
- gate_cycles  in  GATE_W  window length in clk cycles; sampled when start is accepted; 0 is treated as 1.
- start  in  1  request a measurement; level-sampled, accepted only in IDLE.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_count  out  CNT_W  rising-edge count of the last window.
- res_ovf  out  1  count saturated during the last window.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- Synchroniser: SYNC_STAGES flops, then one flop for edge detect. An edge pulse is one clk cycle long and lags sig_in by SYNC_STAGES+1 cycles.
- IDLE, start=1: load gate counter with max(gate_cycles,1), clear edge counter and overflow flag, go to GATE next cycle.
- GATE: each cycle, if edge pulse=1, increment edge counter. Decrement gate counter. Stay exactly N cycles, where N is the loaded value. An edge pulse in the final GATE cycle is counted.
- GATE, increment at all-ones: counter holds all-ones and overflow flag sets. Saturating, no wrap.
- GATE to HOLD: res_count and res_ovf registered from the counters, res_valid=1 on the first HOLD cycle.
- HOLD: res_valid stays high and res_count/res_ovf stay stable until res_valid&&res_ready. In that cycle, go to IDLE; res_valid=0 next cycle.
- res_count/res_ovf keep their last values in IDLE. Only res_valid qualifies them.
- start in GATE or HOLD is ignored, including start in the same cycle as the handshake.
- res_ready without res_valid is ignored.
- Counting range: maximum resolvable input frequency is clk/2. Faster inputs alias, and this is not detected.
- rst_n asserted mid-GATE or mid-HOLD: immediate return to IDLE with outputs cleared. A pending result is discarded.
- State encoding: IDLE, GATE, HOLD (2-bit enum).

Optional Feature:
- Macro: RF_FREQ_CNT_AUTORUN_EN.
- Defined:
  - On leaving GATE, results are latched and res_valid is set.
  - If start is still high, a new window starts on the next cycle, reusing the gate length sampled at the original start. There is no HOLD wait.
  - If a result is still unacknowledged when a new one latches, it is overwritten and res_ovf is also set.
  - Drop start to stop. The block then goes to HOLD and behaves as the non-autorun case.
- Undefined: behaviour exactly as above, with one measurement per start.

Decomposition:
- Shared package rf_test_pkg: state enum type, default CNT_W/GATE_W constants, SYNC_STAGES minimum constant.
- One sub-module, rf_sync_edge: synchroniser chain plus rising-edge detect, with SYNC_STAGES parameter, clk, rst_n, async input and 1-cycle pulse output.

Test Plan:
- Basic count: sig_in square wave, period 10 clk, synchronous to the bench; gate_cycles=1000 → res_count=100, res_ovf=0, res_valid rises exactly 1001 cycles after start accepted.
- Saturation (CNT_W=16): sig_in toggling every clk (period 2), gate_cycles=200000 → res_count=0xFFFF, res_ovf=1.
- Zero/one gate: gate_cycles=0 and gate_cycles=1 both → exactly one GATE cycle. With sig_in static, res_count=0.
- Backpressure: hold res_ready=0 for 50 cycles after res_valid → res_count stable, busy=1, start pulses ignored. Raise res_ready → IDLE next cycle, and a subsequent start is accepted.
- Reset mid-window: assert rst_n=0 in cycle 300 of a 1000-cycle gate → res_valid/busy/res_count=0 immediately. After release, a new start measures correctly from zero.
- Autorun (macro defined): start held high, period 10 clk, gate_cycles=100 → res_valid every 101 cycles with res_count=10. Without ready, the second result sets res_ovf=1. Drop start → one final HOLD.

Source files
------------

// File: rtl/rf_test_pkg.sv
// Shared types and defaults for the RF test-macro measurement blocks.
package rf_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 16;
  localparam int GATE_W_DEF      = 24;
  localparam int SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/rf_freq_counter_if.sv
// Result port of the frequency counter: valid/ready carrying count and overflow.
interface rf_freq_counter_if #(parameter int CNT_W = rf_test_pkg::CNT_W_DEF);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             res_ovf;

  modport master (output res_valid, res_count, res_ovf, input res_ready);
  modport slave  (input res_valid, res_count, res_ovf, output res_ready);
endinterface

// File: rtl/rf_sync_edge.sv
// Synchroniser chain plus registered rising-edge detect; pulse lags async_in by SYNC_STAGES+1 clocks.
module rf_sync_edge
  import rf_test_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
      pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

endmodule

// File: rtl/rf_freq_counter.sv
// Gated rising-edge counter for the RF macro test output, result on a valid/ready port.
// Optional back-to-back windows while start stays high: define RF_FREQ_CNT_AUTORUN_EN.
module rf_freq_counter
  import rf_test_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sig_in,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              start,
  output logic              busy,
  rf_freq_counter_if.master res
);

  // A single-flop chain cannot be made safe; quietly clamp to the minimum.
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf;
  logic              edge_p;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;
  logic              last_gate;
  logic              hs;
  logic [GATE_W-1:0] gate_load;
`ifdef RF_FREQ_CNT_AUTORUN_EN
  logic [GATE_W-1:0] gate_len;
  logic              rearm;
`endif

  rf_sync_edge #(.SYNC_STAGES(SYNC_N)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .pulse    (edge_p)
  );

  always_comb begin
    cnt_nxt = edge_cnt;
    ovf_nxt = ovf;
    if (edge_p) begin
      if (&edge_cnt) ovf_nxt = 1'b1;
      else           cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  assign last_gate = (gate_cnt == GATE_W'(1));
  assign hs        = res.res_valid & res.res_ready;
  assign gate_load = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      ovf           <= 1'b0;
      busy          <= 1'b0;
      res.res_valid <= 1'b0;
      res.res_count <= '0;
      res.res_ovf   <= 1'b0;
`ifdef RF_FREQ_CNT_AUTORUN_EN
      gate_len      <= '0;
      rearm         <= 1'b0;
`endif
    end else begin
      // Handshake can land outside HOLD only when autorun leaves a result pending.
      if (hs) res.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            edge_cnt <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b1;
            state    <= GATE;
`ifdef RF_FREQ_CNT_AUTORUN_EN
            rearm    <= 1'b0;
            if (rearm) begin
              gate_cnt <= gate_len;
            end else begin
              gate_cnt <= gate_load;
              gate_len <= gate_load;
            end
          end else if (rearm) begin
            rearm <= 1'b0;
            busy  <= ~hs;
            state <= hs ? IDLE : HOLD;
`else
            gate_cnt <= gate_load;
`endif
          end
        end
        GATE: begin
          edge_cnt <= cnt_nxt;
          ovf      <= ovf_nxt;
          gate_cnt <= gate_cnt - GATE_W'(1);
          if (last_gate) begin
            res.res_count <= cnt_nxt;
            res.res_valid <= 1'b1;
            state         <= HOLD;
`ifdef RF_FREQ_CNT_AUTORUN_EN
            // An unread result being overwritten is reported as overflow.
            res.res_ovf <= ovf_nxt | (res.res_valid & ~res.res_ready);
            if (start) begin
              state <= IDLE;
              busy  <= 1'b0;
              rearm <= 1'b1;
            end
`else
            res.res_ovf <= ovf_nxt;
`endif
          end
        end
        HOLD: begin
          if (hs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
